// File: rtl/omem_pkg.sv
// Shared constants and state encoding for the output-memory responder.
package omem_pkg;
  localparam int OM_DEPTH = 16;
  localparam int OM_AW    = 4;
  localparam int OM_DW    = 64;

  typedef enum logic [1:0] {INIT, IDLE, RD, HOLD} omem_state_t;
endpackage

// File: rtl/omem_array.sv
// Single-port synchronous RAM; read data is registered and holds until the next read.
module omem_array
  import omem_pkg::*;
#(
  parameter int DEPTH = OM_DEPTH,
  parameter int AW    = OM_AW,
  parameter int DW    = OM_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/omem_responder.sv
// Output-memory responder: array port, post-reset clear sweep and valid/ready drain engine.
// OMEM_CLR_ON_DRAIN_EN: zero each entry as its drain beat is accepted.
module omem_responder
  import omem_pkg::*;
#(
  parameter int DEPTH = OM_DEPTH,
  parameter int AW    = OM_AW,
  parameter int DW    = OM_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN_O,
  input  logic          RW_O,
  input  logic [AW-1:0] ADDR_O,
  input  logic [DW-1:0] WDATA_O,
  output logic [DW-1:0] RDATA_O,
  output logic          INIT_DONE,
  input  logic          DRAIN_START,
  input  logic [AW:0]   DRAIN_LEN,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic [DW-1:0] M_DATA,
  output logic [AW-1:0] M_ADDR,
  output logic          M_LAST,
  output logic          DRAIN_DONE,
  output logic          BUSY
);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IX = AW'(DEPTH-1);

  omem_state_t   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   len_q, len_d;
  logic          done_q, done_d;
  logic          init_done_q;
  logic          src_arr_q;
  logic [DW-1:0] rdata_hold_q, mdata_hold_q;
  logic          we, re, drn_rd, last;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, ram_rdata;
`ifdef OMEM_CLR_ON_DRAIN_EN
  logic          clr_pend_q, clr_pend_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          accept;
  assign accept = (state_q == HOLD) && M_READY;
`endif

  assign last = ({1'b0, ptr_q} == len_q - (AW+1)'(1));

  // Port mux priority: init sweep, array, pending clear, drain read.
  always_comb begin
    we     = 1'b0;
    re     = 1'b0;
    drn_rd = 1'b0;
    addr   = ADDR_O;
    wdata  = WDATA_O;
`ifdef OMEM_CLR_ON_DRAIN_EN
    clr_pend_d = clr_pend_q;
    clr_addr_d = clr_addr_q;
    if (accept && EN_O) begin
      clr_pend_d = 1'b1;
      clr_addr_d = ptr_q;
    end
`endif
    if (state_q == INIT) begin
      we    = 1'b1;
      addr  = cnt_q;
      wdata = '0;
    end else if (EN_O) begin
      we = RW_O;
      re = ~RW_O;
    end
`ifdef OMEM_CLR_ON_DRAIN_EN
    else if (clr_pend_q) begin
      we         = 1'b1;
      addr       = clr_addr_q;
      wdata      = '0;
      clr_pend_d = 1'b0;
    end else if (accept) begin
      we    = 1'b1;
      addr  = ptr_q;
      wdata = '0;
    end
`endif
    else if (state_q == RD) begin
      re     = 1'b1;
      drn_rd = 1'b1;
      addr   = ptr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_IX) state_d = IDLE;
      end
      IDLE: if (DRAIN_START) begin
        len_d   = (DRAIN_LEN == '0 || DRAIN_LEN > DEPTH_L) ? DEPTH_L : DRAIN_LEN;
        ptr_d   = '0;
        state_d = RD;
      end
      RD: if (drn_rd) state_d = HOLD;
      HOLD: if (M_READY) begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          ptr_d   = ptr_q + AW'(1);
          state_d = RD;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      done_q      <= done_d;
      init_done_q <= init_done_q | (state_q == INIT && cnt_q == LAST_IX);
    end
  end

  // The RAM read register is shared; park the other consumer's last word when it is overwritten.
  always_ff @(posedge CLK) begin
    if (RST) begin
      src_arr_q    <= 1'b0;
      rdata_hold_q <= '0;
      mdata_hold_q <= '0;
    end else if (drn_rd) begin
      src_arr_q <= 1'b0;
      if (src_arr_q) rdata_hold_q <= ram_rdata;
    end else if (re) begin
      src_arr_q <= 1'b1;
      if (!src_arr_q) mdata_hold_q <= ram_rdata;
    end
  end

`ifdef OMEM_CLR_ON_DRAIN_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_pend_q <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      clr_pend_q <= clr_pend_d;
      clr_addr_q <= clr_addr_d;
    end
  end
`endif

  omem_array #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_array (
    .clk_i  (CLK),
    .rst_i  (RST),
    .we_i   (we),
    .re_i   (re),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(ram_rdata)
  );

  assign RDATA_O    = src_arr_q ? ram_rdata : rdata_hold_q;
  assign M_DATA     = src_arr_q ? mdata_hold_q : ram_rdata;
  assign M_VALID    = (state_q == HOLD);
  assign M_ADDR     = ptr_q;
  assign M_LAST     = (state_q == HOLD) && last;
  assign DRAIN_DONE = done_q;
  assign INIT_DONE  = init_done_q;
  assign BUSY       = (state_q != IDLE);
endmodule

// File: tb/tb_omem_responder.sv
// Directed + randomized bench for omem_responder against an array-of-words reference model.
module tb_omem_responder;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN_O = 1'b0, RW_O = 1'b0;
  logic [3:0]  ADDR_O = '0;
  logic [63:0] WDATA_O = '0;
  logic [63:0] RDATA_O;
  logic        INIT_DONE;
  logic        DRAIN_START = 1'b0;
  logic [4:0]  DRAIN_LEN = '0;
  logic        M_VALID, M_READY = 1'b0;
  logic [63:0] M_DATA;
  logic [3:0]  M_ADDR;
  logic        M_LAST, DRAIN_DONE, BUSY;

  int total = 0;
  int fails = 0;
  logic [63:0] mdl [16];

  always #5 CLK = ~CLK;

  omem_responder dut (
    .CLK(CLK), .RST(RST), .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
    .RDATA_O(RDATA_O), .INIT_DONE(INIT_DONE), .DRAIN_START(DRAIN_START), .DRAIN_LEN(DRAIN_LEN),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_ADDR(M_ADDR), .M_LAST(M_LAST),
    .DRAIN_DONE(DRAIN_DONE), .BUSY(BUSY)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store is all zero once the sweep completes.
  task automatic init_wait();
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("init_no_done", {63'd0, DRAIN_DONE}, 64'd0);
      if (i == 15) chk("init_done_early", {63'd0, INIT_DONE}, 64'd0);
    end
    chk("init_done", {63'd0, INIT_DONE}, 64'd1);
    chk("idle_busy", {63'd0, BUSY}, 64'd0);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
  endtask

  task automatic arr_wr(input int a, input logic [63:0] d);
    EN_O = 1'b1; RW_O = 1'b1; ADDR_O = 4'(a); WDATA_O = d;
    step();
    EN_O = 1'b0;
    mdl[a] = d;
  endtask

  task automatic arr_rd(input int a);
    EN_O = 1'b1; RW_O = 1'b0; ADDR_O = 4'(a);
    step();
    EN_O = 1'b0;
    chk("arr_rd", RDATA_O, mdl[a]);
  endtask

  // cyc = edges from the DRAIN_START edge until DRAIN_DONE is seen.
  task automatic drain(input int dl, input int stall_b, input int stall_n, input int en_b,
                       input int en_n, input int rst_b, input bit rnd, output int cyc);
    int n, idx, stalled, en_left;
    bit held, rd_chk, acc, seen;
    logic [63:0] sv_data;
    logic [3:0]  sv_addr;
    n = (dl == 0 || dl > 16) ? 16 : dl;
    idx = 0; stalled = 0; en_left = 0; held = 0; rd_chk = 0; seen = 0; cyc = 0;
    sv_data = '0; sv_addr = '0;
    DRAIN_LEN = 5'(dl); DRAIN_START = 1'b1;
    step();
    DRAIN_START = 1'b0;
    while (!seen && cyc < 300) begin
      acc = 0;
      if (rd_chk) chk("rd_during_drain", RDATA_O, mdl[15]);
      rd_chk = 0;
      if (DRAIN_DONE) seen = 1;
      else begin
        EN_O = 1'b0;
        if (en_left > 0) begin
          EN_O = 1'b1; RW_O = 1'b0; ADDR_O = 4'd15; en_left--; rd_chk = 1;
        end
        M_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (M_VALID) begin
          if (idx >= n) chk("extra_beat", {63'd0, M_VALID}, 64'd0);
          else begin
            if (rst_b == idx) begin
              RST = 1'b1; M_READY = 1'b0; EN_O = 1'b0;
              step();
              chk("rst_mvalid", {63'd0, M_VALID}, 64'd0);
              chk("rst_done", {63'd0, DRAIN_DONE}, 64'd0);
              chk("rst_init_done", {63'd0, INIT_DONE}, 64'd0);
              chk("rst_maddr", {60'd0, M_ADDR}, 64'd0);
              RST = 1'b0;
              init_wait();
              cyc = -1;
              return;
            end
            if (held) begin
              chk("stall_data", M_DATA, sv_data);
              chk("stall_addr", {60'd0, M_ADDR}, {60'd0, sv_addr});
            end
            chk("beat_addr", {60'd0, M_ADDR}, 64'(idx));
            chk("beat_data", M_DATA, mdl[idx]);
            chk("beat_last", {63'd0, M_LAST}, {63'd0, idx == n - 1});
            if (idx == stall_b && stalled < stall_n) begin
              M_READY = 1'b0; stalled++;
            end
            acc = M_READY; held = !M_READY; sv_data = M_DATA; sv_addr = M_ADDR;
          end
        end
        step();
        cyc++;
        if (acc) begin
`ifdef OMEM_CLR_ON_DRAIN_EN
          mdl[idx] = '0;
`endif
          if (idx == en_b) en_left = en_n;
          idx++;
        end
      end
    end
    EN_O = 1'b0; M_READY = 1'b0;
    chk("done_seen", {63'd0, seen}, 64'd1);
    chk("beat_count", 64'(idx), 64'(n));
    step();
    chk("done_pulse", {63'd0, DRAIN_DONE}, 64'd0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    RST = 1'b1;
    step(); step();
    chk("rst_rdata", RDATA_O, 64'd0);
    chk("rst_mdata", M_DATA, 64'd0);
    chk("rst_mvalid0", {63'd0, M_VALID}, 64'd0);
    chk("rst_mlast", {63'd0, M_LAST}, 64'd0);
    chk("rst_done0", {63'd0, DRAIN_DONE}, 64'd0);
    chk("rst_initdone0", {63'd0, INIT_DONE}, 64'd0);
    chk("rst_busy", {63'd0, BUSY}, 64'd1);
    RST = 1'b0;
    init_wait();

    arr_rd(5);
    arr_wr(3, 64'h0001_0002_0003_0004);
    arr_rd(3);

    for (int i = 0; i < 16; i++) arr_wr(i, {$urandom, $urandom});
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) arr_wr(int'($urandom_range(0, 15)), {$urandom, $urandom});
      else arr_rd(int'($urandom_range(0, 15)));
    end

    for (int k = 0; k < 4; k++) arr_wr(k, 64'(k + 1));
    drain(4, -1, 0, -1, 0, -1, 1'b0, cyc);
    chk("lat_base", 64'(cyc), 64'd8);
    for (int k = 0; k < 4; k++) arr_rd(k);

    for (int k = 0; k < 4; k++) arr_wr(k, {$urandom, $urandom});
    drain(4, 1, 5, 2, 3, -1, 1'b0, cyc);
    chk("lat_stall", 64'(cyc), 64'd16);
    for (int k = 0; k < 4; k++) arr_rd(k);

    for (int k = 0; k < 16; k++) arr_wr(k, {$urandom, $urandom});
    drain(20, -1, 0, -1, 0, -1, 1'b1, cyc);
    for (int k = 0; k < 16; k++) arr_rd(k);

    for (int k = 0; k < 16; k++) arr_wr(k, {$urandom, $urandom});
    drain(0, -1, 0, -1, 0, 7, 1'b0, cyc);
    arr_rd(2);
    arr_rd(9);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
